cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Execution controller between the front-panel debouncers and the CPU core. It consumes the single-cycle debounced button pulses (step, run/stop, burst) and the core's halt indication. It produces a registered clock-enable, `cpu_en`, that gates every architectural state update in the core. It provides single-step, fixed-length burst, and free-run modes, plus a retired-cycle counter for the display.

## Interface
Parameters:
- `BURST_LEN`, default 16: number of `cpu_en` cycles per burst; legal range ≥ 1.
- `RUN_DIV`, default 1: run mode asserts `cpu_en` once every `RUN_DIV` clocks; legal range ≥ 1.
- `CNT_W`, default 32: width of `cycle_count`.

Ports:
- `clk` input, 1 bit: the single system clock; all logic is on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `step_pulse` input, 1 bit: debounced one-cycle pulse; request one enable cycle.
- `run_pulse` input, 1 bit: debounced one-cycle pulse; toggle free-run, and clear halt.
- `burst_pulse` input, 1 bit: debounced one-cycle pulse; request `BURST_LEN` enable cycles.
- `halt_in` input, 1 bit: level from the core; high while the core has executed HALT.
- `cpu_en` output, 1 bit: registered clock-enable to the core.
- `running` output, 1 bit: high in RUN or BURST.
- `halted` output, 1 bit: high in HALTED.
- `cycle_count` output, `CNT_W` bits: number of `cpu_en` cycles issued, modulo 2^`CNT_W`.

## Operation
- States are IDLE, RUN, BURST and HALTED.
- While `rst_n` is low, the block holds: state IDLE, `cpu_en`=0, `running`=0, `halted`=0, `cycle_count`=0, burst and divider counters at 0.
- Input priority within one cycle: `halt_in` > `run_pulse` > `burst_pulse` > `step_pulse`. Lower-priority inputs in the same cycle are dropped, not queued.
- Any state except HALTED with `halt_in`=1 goes to HALTED, and `cpu_en` is 0 from the next cycle onward.
- IDLE:
  - `run_pulse` goes to RUN.
  - `burst_pulse` goes to BURST and loads the remaining count with `BURST_LEN`.
  - `step_pulse` stays in IDLE and registers `cpu_en`=1 for exactly one cycle.
- RUN:
  - The divider resets to 0 on entry.
  - `cpu_en`=1 when the divider is 0; the divider then counts 1..`RUN_DIV`-1 and wraps to 0.
  - With `RUN_DIV`=1, `cpu_en` is high continuously.
  - `run_pulse` goes to IDLE.
  - `step_pulse` and `burst_pulse` are ignored.
- BURST:
  - `cpu_en`=1 on every cycle and the remaining count decrements.
  - When the last enable is issued (remaining=1), the block goes to IDLE.
  - `run_pulse` aborts the burst and goes to IDLE without issuing a further `cpu_en`.
  - `step_pulse` and `burst_pulse` are ignored.
- HALTED:
  - `cpu_en`=0.
  - `run_pulse` with `halt_in`=0 goes to IDLE.
  - `run_pulse` with `halt_in`=1 is ignored.
  - `step_pulse` and `burst_pulse` are ignored.
- `cycle_count` increments by 1 on every clock where `cpu_en`=1 and wraps from all-ones to 0 with no flag.
- `running` and `halted` are decoded from the registered state, so they are glitch-free.
- An asynchronous reset assertion in any state, including mid-burst, returns every output to its reset value immediately. No partial burst resumes after reset.

## Timing
- Request latency: a pulse sampled high at edge k (state IDLE) gives `cpu_en` high during cycle k+1, i.e. after edge k.
- The state change and `running` update are visible at the same edge.
- Step: exactly one `cpu_en` cycle per accepted `step_pulse`.
- Back-to-back step pulses at edges k and k+1 give `cpu_en` high in two consecutive cycles.
- Burst: `cpu_en` is high for exactly `BURST_LEN` consecutive cycles starting at k+1. `running` drops at the same edge as `cpu_en` drops.
- Halt: `halt_in` sampled high at edge h. The enable cycle already registered before h still completes. `cpu_en` is 0 from edge h and `halted`=1 from edge h.
- Run stop: `run_pulse` at edge s forces `cpu_en`=0 from edge s.
- There is no combinational path from any input to any output.

## Test plan
- Reset, then `step_pulse` at edge 5 → `cpu_en` high only in cycle 6; `cycle_count`=1; `running` stays 0.
- `BURST_LEN`=16, `burst_pulse` at edge 10 → `cpu_en` high for cycles 11..26 inclusive; `cycle_count`=16; state returns to IDLE at edge 26; a `step_pulse` at edge 15 has no effect.
- `RUN_DIV`=4, `run_pulse` at edge 3, `run_pulse` again at edge 20:
  - `cpu_en` is high in cycles 4, 8, 12, 16, 20 and low from edge 20 onward.
  - `cycle_count`=5.
- RUN with `RUN_DIV`=1, `halt_in` rising at edge 30 → `cpu_en` is 0 from edge 30 and `halted`=1.
  - `run_pulse` at edge 35 while `halt_in`=1 → stays HALTED.
  - `halt_in` falls at edge 40, `run_pulse` at edge 42 → IDLE, `halted`=0.
- Simultaneous `run_pulse`+`burst_pulse`+`step_pulse` in IDLE → RUN is entered and no burst count is loaded.
  - Separately, with `CNT_W`=4, issue 17 steps → `cycle_count`=1.
- `rst_n` pulsed low during cycle 5 of a 16-cycle burst → all outputs return to 0 asynchronously; after release the state is IDLE and `cpu_en` stays 0 with no pending burst.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: execution controller for the CPU core.
// Turns debounced step / run / burst pulses and the core's halt level into a
// registered clock-enable (cpu_en), and counts the enable cycles it has issued.
// Input priority in one cycle: halt_in > run_pulse > burst_pulse > step_pulse.
module cpu_run_ctrl #(
  parameter int BURST_LEN = 16,
  parameter int RUN_DIV   = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_pulse,
  input  logic             run_pulse,
  input  logic             burst_pulse,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  // Remaining-burst counter must hold BURST_LEN itself; divider holds 0..RUN_DIV-1.
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_BURST  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_en;
  logic             w_en_next;
  logic [BW-1:0]    r_rem;
  logic [BW-1:0]    w_rem_next;
  logic [DW-1:0]    r_div;
  logic [DW-1:0]    w_div_next;
  logic [DW-1:0]    w_div_inc;
  logic [CNT_W-1:0] r_cnt;

  // Free-run divider phase advance: counts 0..RUN_DIV-1 and wraps.
  always_comb begin
    if (r_div == DW'(RUN_DIV - 1)) begin
      w_div_inc = '0;
    end else begin
      w_div_inc = r_div + DW'(1);
    end
  end

  // Next-state and next-enable decode; the enable is registered so the core
  // sees a clean, glitch-free gate one cycle after the request is sampled.
  always_comb begin
    w_state_next = r_state;
    w_en_next    = 1'b0;
    w_rem_next   = r_rem;
    w_div_next   = r_div;
    if ((r_state != S_HALTED) && halt_in) begin
      // Halt wins over everything; any burst in progress is discarded.
      w_state_next = S_HALTED;
      w_rem_next   = '0;
      w_div_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run_pulse) begin
            w_state_next = S_RUN;
            w_div_next   = '0;
            w_en_next    = 1'b1;
          end else if (burst_pulse) begin
            w_state_next = S_BURST;
            w_rem_next   = BW'(BURST_LEN);
            w_en_next    = 1'b1;
          end else if (step_pulse) begin
            w_en_next    = 1'b1;
          end
        end
        S_RUN: begin
          if (run_pulse) begin
            w_state_next = S_IDLE;
            w_div_next   = '0;
          end else begin
            w_div_next   = w_div_inc;
            w_en_next    = (w_div_inc == '0);
          end
        end
        S_BURST: begin
          // r_rem counts the enable currently on the output as still pending,
          // so reaching 1 means the last enable is being issued right now.
          if (run_pulse || (r_rem == BW'(1))) begin
            w_state_next = S_IDLE;
            w_rem_next   = '0;
          end else begin
            w_rem_next   = r_rem - BW'(1);
            w_en_next    = 1'b1;
          end
        end
        S_HALTED: begin
          if (run_pulse && !halt_in) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State, enable and counter registers; reset aborts any burst outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_en    <= 1'b0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_en    <= w_en_next;
      r_rem   <= w_rem_next;
      r_div   <= w_div_next;
      r_cnt   <= r_cnt + CNT_W'(r_en);
    end
  end

  assign cpu_en      = r_en;
  assign running     = (r_state == S_RUN) || (r_state == S_BURST);
  assign halted      = (r_state == S_HALTED);
  assign cycle_count = r_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: the driver feeds directed and random
// pulses, an edge-level reference model pushes the expected outputs, and a
// negedge monitor pops and compares them.
module tb_cpu_run_ctrl;

  localparam int BL = 5;
  localparam int RD = 3;
  localparam int CW = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BURST = 2;
  localparam int M_HALT  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_pulse = 1'b0;
  logic          run_pulse = 1'b0;
  logic          burst_pulse = 1'b0;
  logic          halt_in = 1'b0;
  logic          cpu_en;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycle_count;

  typedef struct packed {
    logic          en;
    logic          run;
    logic          hlt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   mon_n = 0;

  // Reference model state: mode plus edge-number bookkeeping.
  int   mode = M_IDLE;
  int   edge_n = 0;
  int   run_start = 0;
  int   burst_end = 0;
  bit   m_en = 1'b0;
  int   m_cnt = 0;

  cpu_run_ctrl #(.BURST_LEN(BL), .RUN_DIV(RD), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_pulse (step_pulse),
    .run_pulse  (run_pulse),
    .burst_pulse(burst_pulse),
    .halt_in    (halt_in),
    .cpu_en     (cpu_en),
    .running    (running),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Reference: what the outputs look like after an edge with these inputs.
  function automatic void model_edge(input bit s, input bit r, input bit b, input bit h);
    exp_t e;
    edge_n++;
    m_cnt = (m_cnt + int'(m_en)) % (1 << CW);
    if (mode != M_HALT && h) begin
      mode = M_HALT;
      m_en = 1'b0;
    end else begin
      case (mode)
        M_IDLE: begin
          if (r) begin
            mode = M_RUN; run_start = edge_n; m_en = 1'b1;
          end else if (b) begin
            mode = M_BURST; burst_end = edge_n + BL; m_en = 1'b1;
          end else begin
            m_en = s;
          end
        end
        M_RUN: begin
          if (r) begin
            mode = M_IDLE; m_en = 1'b0;
          end else begin
            m_en = (((edge_n - run_start) % RD) == 0);
          end
        end
        M_BURST: begin
          if (r || edge_n >= burst_end) begin
            mode = M_IDLE; m_en = 1'b0;
          end else begin
            m_en = 1'b1;
          end
        end
        default: begin
          if (r && !h) mode = M_IDLE;
          m_en = 1'b0;
        end
      endcase
    end
    e.en  = m_en;
    e.run = (mode == M_RUN) || (mode == M_BURST);
    e.hlt = (mode == M_HALT);
    e.cnt = CW'(m_cnt);
    q.push_back(e);
  endfunction

  // One clock of stimulus: pulses last one cycle, halt_in is a level.
  task automatic cycle(input bit s, input bit r, input bit b, input bit h);
    step_pulse  = s;
    run_pulse   = r;
    burst_pulse = b;
    halt_in     = h;
    @(posedge clk);
    model_edge(s, r, b, h);
    #1;
    step_pulse  = 1'b0;
    run_pulse   = 1'b0;
    burst_pulse = 1'b0;
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, h);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({cpu_en, running, halted, cycle_count} !== '0) begin
      errors++;
      $display("FAIL %s: got en=%0b run=%0b halt=%0b cnt=%0d, want all 0",
               name, cpu_en, running, halted, cycle_count);
    end else begin
      $display("%s: outputs at reset value", name);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic reset_mid();
    #1;
    q.delete();
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode  = M_IDLE;
    m_en  = 1'b0;
    m_cnt = 0;
  endtask

  // Monitor: one comparison per presented output cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_n++;
      checks++;
      if ({cpu_en, running, halted, cycle_count} !== mon_e) begin
        errors++;
        $display("FAIL cyc%0d: got en=%0b run=%0b halt=%0b cnt=%0d, want en=%0b run=%0b halt=%0b cnt=%0d",
                 mon_n, cpu_en, running, halted, cycle_count,
                 mon_e.en, mon_e.run, mon_e.hlt, mon_e.cnt);
      end else begin
        $display("cyc%0d en=%0b run=%0b halt=%0b cnt=%0d ok",
                 mon_n, cpu_en, running, halted, cycle_count);
      end
    end
  end

  bit rs, rr, rb, rh;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;

    // Single step: one enable, count 1, running never set.
    idle(3, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Burst with an ignored step in the middle.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);

    // Back-to-back steps give two consecutive enables.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Divided free-run, then stop.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Halt during run; run while halted ignored; release and resume.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(3, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Simultaneous pulses in IDLE: run wins, no burst loaded.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(BL + 2, 1'b0);

    // Run aborting a burst.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Halt mid-burst, then clear.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);
    idle(1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Seventeen steps: counter wraps modulo 16.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a burst; no burst resumes afterwards.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    reset_mid();
    idle(BL + 3, 1'b0);

    // Randomised stimulus.
    rh = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 9) == 0);
      rb = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) rh = ~rh;
      cycle(rs, rr, rb, rh);
    end
    idle(2, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
